// File: rtl/core_exu_issue_ctrl.sv
// Issue control between IDU and EXU.
// Holds decoded instructions back on register hazards (busy-map scoreboard)
// or when the in-flight limit is reached. After a branch it stalls until the
// branch resolves, and it pulses a flush when the jump is taken.
module core_exu_issue_ctrl #(
    parameter int MAX_INFLIGHT = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        idu_valid,
    output logic        idu_ready,
    input  logic [4:0]  idu_rs1_idx,
    input  logic [4:0]  idu_rs2_idx,
    input  logic [4:0]  idu_rd_idx,
    input  logic        idu_rs1_used,
    input  logic        idu_rs2_used,
    input  logic        idu_rd_wen,
    input  logic        idu_is_bc,
    output logic        exu_rx_valid,
    input  logic        exu_rx_ready,
    input  logic        exu_tx_bc_done,
    input  logic        exu_tx_bc_en,
    input  logic        wbu_wb_valid,
    input  logic [4:0]  wbu_wb_rd_idx,
    output logic        ctrl_flush,
    output logic [31:0] ctrl_busy_map,
    output logic [2:0]  ctrl_inflight,
    output logic        ctrl_err
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_BR_WAIT = 2'd1,
        S_FLUSH   = 2'd2
    } state_t;

    localparam logic [2:0] MAX_CNT = 3'(MAX_INFLIGHT);

    state_t      state_q, state_d;
    logic [31:0] busy_q, busy_d;
    logic [2:0]  inflight_q, inflight_d;
    logic        flush_q;
    logic        err_q, err_d;

    logic        hazard;
    logic        full;
    logic        issue;

    // Hazard check uses only the registered busy map, so a retire frees a
    // dependent instruction on the following cycle. x0 never hazards.
    always_comb begin
        hazard = (idu_rs1_used && (idu_rs1_idx != 5'd0) && busy_q[idu_rs1_idx])
              || (idu_rs2_used && (idu_rs2_idx != 5'd0) && busy_q[idu_rs2_idx])
              || (idu_rd_wen   && (idu_rd_idx  != 5'd0) && busy_q[idu_rd_idx]);
    end

    assign full         = (inflight_q == MAX_CNT);
    assign exu_rx_valid = idu_valid && (state_q == S_RUN) && !hazard && !full;
    assign idu_ready    = exu_rx_valid && exu_rx_ready;
    assign issue        = idu_valid && idu_ready;

    // Per-register busy bit: a new pending write outranks a same-cycle retire.
    assign busy_d[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_busy
            assign busy_d[gi] = (issue && idu_rd_wen && (idu_rd_idx == 5'(gi)))
                             || (busy_q[gi] && !(wbu_wb_valid && (wbu_wb_rd_idx == 5'(gi))));
        end
    endgenerate

    // In-flight count and the sticky error for a retire with nothing in flight.
    always_comb begin
        inflight_d = inflight_q;
        err_d      = err_q;
        if (issue && !wbu_wb_valid) begin
            inflight_d = inflight_q + 3'd1;
        end else if (wbu_wb_valid && !issue && (inflight_q != 3'd0)) begin
            inflight_d = inflight_q - 3'd1;
        end
        if (wbu_wb_valid && (inflight_q == 3'd0)) begin
            err_d = 1'b1;
        end
    end

    // Branch FSM next state: stall after a branch issues, flush if it is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (issue && idu_is_bc) state_d = S_BR_WAIT;
            end
            S_BR_WAIT: begin
                if (exu_tx_bc_done) state_d = exu_tx_bc_en ? S_FLUSH : S_RUN;
            end
            S_FLUSH: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // State register. The flush flag is registered so it is high exactly while in S_FLUSH.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_RUN;
            busy_q     <= 32'd0;
            inflight_q <= 3'd0;
            flush_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
            flush_q    <= (state_d == S_FLUSH);
            err_q      <= err_d;
        end
    end

    assign ctrl_flush    = flush_q;
    assign ctrl_busy_map = busy_q;
    assign ctrl_inflight = inflight_q;
    assign ctrl_err      = err_q;

endmodule

// File: doc/core_exu_issue_ctrl.md
CORE_EXU_ISSUE_CTRL -- requirements
Module: core_exu_issue_ctrl

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 2, meaning the maximum number of issued-but-not-written-back instructions (legal range 1-7).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 SHALL have ports idu_valid input 1 and idu_ready output 1, the decoded-instruction handshake from IDU.
REQ-005 SHALL have ports idu_rs1_idx, idu_rs2_idx, idu_rd_idx, each input 5, holding the source and destination register indices.
REQ-006 SHALL have ports idu_rs1_used, idu_rs2_used, idu_rd_wen, idu_is_bc, each input 1: source read, rd written, and branch/jal/jalr flags.
REQ-007 SHALL have ports exu_rx_valid output 1 and exu_rx_ready input 1, the issue handshake to EXU.
REQ-008 SHALL have ports exu_tx_bc_done input 1 and exu_tx_bc_en input 1: branch resolved, and jump taken.
REQ-009 SHALL have ports wbu_wb_valid input 1 and wbu_wb_rd_idx input 5, the writeback retire event.
REQ-010 SHALL have port ctrl_flush  output  1  one-cycle pulse telling IFU/IDU to discard fetched work.
REQ-011 SHALL have port ctrl_busy_map  output  32  registered scoreboard of pending rd writes.
REQ-012 SHALL have port ctrl_inflight  output  3  registered in-flight instruction count.
REQ-013 SHALL have port ctrl_err  output  1  sticky flag set on a writeback that arrives with zero instructions in flight.

Function
REQ-014 SHALL implement FSM states S_RUN, S_BR_WAIT, S_FLUSH.
REQ-015 hazard SHALL equal (rs1_used && busy[rs1]) || (rs2_used && busy[rs2]) || (rd_wen && busy[rd]), where index 0 never hazards.
REQ-016 hazard SHALL use the registered busy map, with no same-cycle writeback bypass; a retire enables a dependent issue on the next cycle.
REQ-017 full SHALL equal (ctrl_inflight == MAX_INFLIGHT).
REQ-018 exu_rx_valid SHALL equal idu_valid && state==S_RUN && !hazard && !full, combinationally.
REQ-019 idu_ready SHALL equal exu_rx_valid && exu_rx_ready; issue = idu_valid && idu_ready.
REQ-020 On issue with rd_wen && rd!=0, busy[rd] SHALL be set next cycle.
REQ-021 On wbu_wb_valid, busy[wbu_wb_rd_idx] SHALL be cleared next cycle; bit 0 SHALL always read 0.
REQ-022 If a set and a clear target the same index in the same cycle, the set SHALL win.
REQ-023 ctrl_inflight SHALL: +1 on issue only, -1 on wbu_wb_valid only, hold on both or neither, and never go below 0.
REQ-024 wbu_wb_valid while ctrl_inflight==0 SHALL set ctrl_err, which holds until reset; the busy clear SHALL still apply.
REQ-025 S_RUN: an issue with idu_is_bc=1 SHALL move to S_BR_WAIT; otherwise stay.
REQ-026 S_BR_WAIT: no issue; exu_tx_bc_done && exu_tx_bc_en -> S_FLUSH; exu_tx_bc_done && !exu_tx_bc_en -> S_RUN; else stay.
REQ-027 S_FLUSH: ctrl_flush=1 for exactly this one cycle, no issue; unconditional -> S_RUN.
REQ-028 ctrl_flush SHALL be registered and high only while in S_FLUSH.
REQ-029 exu_tx_bc_done seen in S_RUN or S_FLUSH SHALL be ignored.
REQ-030 Scoreboard and counter updates SHALL continue in every state, including S_FLUSH.
REQ-031 Issue latency SHALL be 0 cycles (combinational pass) when no hazard, not full, and state is S_RUN.

Reset
REQ-032 While rstn=0 at a clk edge: state=S_RUN, busy map=0, ctrl_inflight=0, ctrl_flush=0, ctrl_err=0.
REQ-033 During reset, exu_rx_valid and idu_ready SHALL be 0 because of REQ-018, given idu_valid is qualified by the reset state.
REQ-034 Reset asserted mid-operation SHALL discard all pending state at that edge, with no flush pulse emitted.

Verification
REQ-035 Issue add rd=5 then add rs1=5 back-to-back, writeback rd=5 at cycle 3 -> second instruction is held (exu_rx_valid=0) through cycle 3 and issues at cycle 4; busy[5] goes 1 then 0.
REQ-036 MAX_INFLIGHT=2, three independent instructions, no writeback -> two issue, third stalls with ctrl_inflight=2; one writeback -> third issues on the next cycle.
REQ-037 Issue a branch with idu_is_bc=1, then bc_done=1 and bc_en=1 -> S_BR_WAIT, one-cycle ctrl_flush=1, then S_RUN; no issue between the branch and the flush.
REQ-038 Not-taken branch (bc_done=1, bc_en=0) -> returns to S_RUN, ctrl_flush stays 0, next instruction issues on the following cycle.
REQ-039 Issue and writeback in the same cycle -> ctrl_inflight unchanged; writeback with ctrl_inflight=0 -> ctrl_err=1 and it stays 1.
REQ-040 Assert rstn=0 while in S_BR_WAIT with busy[7] set -> next cycle all outputs are at reset values and busy map=0.
